cordic_arbiter: RTL and testbench
=================================

// Module: cordic_arbiter
// PURPOSE
//   Shares one cordic pipeline among NUM_REQ requesters.
//   - Round-robin arbitration with valid/ready on the request side.
//   - Tracks each issued operation's requester id in a tag pipe aligned to the
//     cordic latency, and routes each result back to its originator.
//   - Drain/halt control lets software quiesce the pipeline before reconfiguration.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   DATA_W    49  request/result width: {func[48], x[47:32], y[31:16], z[15:0]}
//   CDC_LAT   10  cycles from o_cdc_vld to matching i_cdc_vld (= cordic NUM_STAGE + 2)
//   ID_W      $clog2(NUM_REQ)  tag width (localparam)
// PORTS
//   i_clk       in   1               clock, rising edge
//   i_rst_n     in   1               asynchronous reset, active low
//   i_req_vld   in   NUM_REQ         request valid, one per requester
//   i_req_data  in   NUM_REQ*DATA_W  request payload; requester k occupies [k*DATA_W +: DATA_W]
//   o_req_rdy   out  NUM_REQ         one-hot grant; transfer occurs when vld & rdy
//   o_cdc_vld   out  1               to cordic i_vld (registered)
//   o_cdc_data  out  DATA_W          to cordic i_data (registered)
//   i_cdc_vld   in   1               from cordic o_vld
//   i_cdc_data  in   DATA_W          from cordic o_data
//   o_rsp_vld   out  NUM_REQ         one-hot result strobe to the owning requester (registered)
//   o_rsp_data  out  DATA_W          result payload, shared by all requesters (registered)
//   i_drain     in   1               level: stop accepting, empty the pipe, then halt
//   o_idle      out  1               1 in HALT state
//   o_err       out  1               sticky tag/valid mismatch flag
// BEHAVIOUR
//   Reset: all outputs 0, rr pointer 0, tag pipe empty, outstanding = 0, FSM = RUN.
//   FSM:
//     - RUN: grants allowed. i_drain=1 -> DRAIN; no grant in that same cycle.
//     - DRAIN: no grants. Go to HALT when outstanding == 0 and no result is in flight.
//     - HALT: o_idle=1, no grants. i_drain=0 -> RUN.
//     - i_drain deasserted while in DRAIN: finish draining, then HALT for 1 cycle, then RUN.
//   Arbitration (combinational o_req_rdy, RUN & !i_drain only):
//     - Grant the first requester with vld, searching ptr, ptr+1, ... mod NUM_REQ.
//     - On a transfer, ptr <= granted+1 (wraps NUM_REQ-1 -> 0). With no transfer, ptr holds.
//     - At most one grant per cycle.
//     - A requester's vld may drop while unserved; the arbiter imposes no stickiness.
//   Issue: transfer at cycle t -> o_cdc_vld=1 with granted data at t+1.
//     o_cdc_vld is 0 on non-transfer cycles; o_cdc_data holds its last value.
//   Tag pipe: CDC_LAT-deep shift register of {vld, id}. It shifts every cycle and
//     is written at the o_cdc_vld stage.
//   Return, at the pipe tail:
//     - tail.vld & i_cdc_vld: o_rsp_vld[tail.id]=1 and o_rsp_data=i_cdc_data at the
//       next cycle. End-to-end latency = CDC_LAT + 2 cycles.
//     - tail.vld != i_cdc_vld: drop the result/entry, set o_err (cleared only by reset),
//       and still decrement outstanding if tail.vld.
//   Outstanding counter (width $clog2(CDC_LAT+2)):
//     - +1 on issue, -1 on tail retire.
//     - A simultaneous issue and retire leaves it unchanged.
//   No backpressure on results: requesters must always accept o_rsp_vld.
//   Reset mid-operation: in-flight tags are discarded. The cordic must share the same reset.
// CONFIGURATION
//   CORDIC_ARB_STATS_EN defined:
//     - Adds output o_issue_cnt [NUM_REQ*16]: per-requester count of issued operations.
//     - Each count is 16-bit, saturates at 16'hFFFF, and resets to 0.
//   CORDIC_ARB_STATS_EN not defined: port and counters are absent; all other behaviour is identical.
// STRUCTURE
//   Package cordic_arb_pkg:
//     - DATA_W default, field offsets X/Y/Z/FUNC.
//     - FSM state encoding: RUN=2'd0, DRAIN=2'd1, HALT=2'd2.
//     - tag_t {vld, id}.
//   Sub-module rr_arbiter (NUM_REQ): inputs req and ptr, outputs one-hot grant and grant index.
//   The tag pipe, FSM and counters live in cordic_arbiter.
// TESTING
//   1. One requester: req1 issues data 49'h0_4000_0000_2000 at t.
//      -> o_cdc_vld at t+1; model cordic returns it at t+11; o_rsp_vld=4'b0010 at t+12.
//   2. All 4 requesters hold vld, ptr=0.
//      -> grants 0,1,2,3,0,... on consecutive cycles; o_rsp_vld order is identical,
//         each CDC_LAT+2 after its grant.
//   3. i_drain=1 with 3 operations in flight.
//      -> o_req_rdy=0 from the same cycle; all 3 responses delivered;
//         o_idle=1 the cycle after the last retire; drain=0 -> grants resume next cycle.
//   4. Spurious i_cdc_vld with empty tag pipe.
//      -> no o_rsp_vld; o_err=1 and stays 1 until i_rst_n=0.
//   5. Assert i_rst_n=0 with 5 in flight, then release.
//      -> outputs 0, outstanding 0, no stale o_rsp_vld; o_idle=0.
//   6. (STATS_EN) req2 issues 70000 times.
//      -> o_issue_cnt[32 +: 16] = 16'hFFFF, other counts unaffected.

Source files
------------

// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the cordic request arbiter.
// Field layout of one cordic operation word: {func, x, y, z}.
package cordic_arb_pkg;

  localparam int unsigned DATA_W_DEF = 49;
  localparam int unsigned FIELD_W    = 16;
  localparam int unsigned Z_LSB      = 0;
  localparam int unsigned Y_LSB      = 16;
  localparam int unsigned X_LSB      = 32;
  localparam int unsigned FUNC_BIT   = 48;

  // Tag id is sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [DATA_W_DEF-1:0] pack_op(input logic               func,
                                                    input logic [FIELD_W-1:0] x,
                                                    input logic [FIELD_W-1:0] y,
                                                    input logic [FIELD_W-1:0] z);
    logic [DATA_W_DEF-1:0] w;
    w                    = '0;
    w[FUNC_BIT]          = func;
    w[X_LSB +: FIELD_W]  = x;
    w[Y_LSB +: FIELD_W]  = y;
    w[Z_LSB +: FIELD_W]  = z;
    return w;
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Request, cordic-side and response signals of the cordic arbiter.
interface cordic_arbiter_if
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        i_req_vld;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]        o_req_rdy;
  logic                      o_cdc_vld;
  logic [DATA_W-1:0]         o_cdc_data;
  logic                      i_cdc_vld;
  logic [DATA_W-1:0]         i_cdc_data;
  logic [NUM_REQ-1:0]        o_rsp_vld;
  logic [DATA_W-1:0]         o_rsp_data;

  modport slave (
    input  i_req_vld, i_req_data, i_cdc_vld, i_cdc_data,
    output o_req_rdy, o_cdc_vld, o_cdc_data, o_rsp_vld, o_rsp_data
  );

  modport master (
    output i_req_vld, i_req_data, i_cdc_vld, i_cdc_data,
    input  o_req_rdy, o_cdc_vld, o_cdc_data, o_rsp_vld, o_rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt_c,
  output logic [ID_W-1:0]    o_gnt_idx_c
);

  logic w_found;

  // Upper segment [ptr, NUM_REQ) has priority over the wrapped segment [0, ptr).
  always_comb begin
    o_gnt_c     = '0;
    o_gnt_idx_c = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k] && (ID_W'(k) >= i_ptr)) begin
        o_gnt_c[k]  = 1'b1;
        o_gnt_idx_c = ID_W'(k);
        w_found     = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[k]) begin
        o_gnt_c[k]  = 1'b1;
        o_gnt_idx_c = ID_W'(k);
        w_found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic pipeline among NUM_REQ requesters with tag-based result routing
// and drain/halt control. Optional per-requester issue counters: CORDIC_ARB_STATS_EN.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CDC_LAT = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  cordic_arbiter_if.slave cdc_bus,
  input  logic            i_drain,
  output logic            o_idle,
  output logic            o_err
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] o_issue_cnt
`endif
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned OUT_W = $clog2(CDC_LAT + 2);

  logic [1:0]         r_state, w_state_nxt;
  logic [ID_W-1:0]    r_ptr, w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_gnt_en, w_xfer, w_retire;
  logic [DATA_W-1:0]  w_sel_data, r_cdc_data, r_rsp_data;
  tag_t               r_cdc_tag, w_tail;
  tag_t               r_tag [CDC_LAT];
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [OUT_W-1:0]   r_outst, w_outst_nxt;
  logic               r_err;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req       (cdc_bus.i_req_vld),
    .i_ptr       (r_ptr),
    .o_gnt_c     (w_gnt),
    .o_gnt_idx_c (w_gnt_idx)
  );

  assign w_gnt_en          = (r_state == ST_RUN) && !i_drain;
  assign cdc_bus.o_req_rdy = w_gnt_en ? w_gnt : '0;
  assign w_xfer            = w_gnt_en && (|w_gnt);
  assign w_tail            = r_tag[CDC_LAT-1];
  assign w_retire          = w_tail.vld;

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) w_sel_data = cdc_bus.i_req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    w_outst_nxt = r_outst;
    if (w_xfer && !w_retire)      w_outst_nxt = r_outst + OUT_W'(1);
    else if (!w_xfer && w_retire) w_outst_nxt = r_outst - OUT_W'(1);
  end

  // Halt is entered as soon as the last outstanding tag retires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (i_drain) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_outst_nxt == '0) w_state_nxt = ST_HALT;
      ST_HALT:  if (!i_drain) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_ptr   <= '0;
      r_outst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      if (w_xfer) r_ptr <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cdc_tag  <= '0;
      r_cdc_data <= '0;
    end else begin
      r_cdc_tag <= '{vld: w_xfer, id: TAG_ID_W'(w_gnt_idx)};
      if (w_xfer) r_cdc_data <= w_sel_data;
    end
  end

  // Tag pipe entry 0 is loaded from the issue stage so the tail meets i_cdc_vld.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < CDC_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= r_cdc_tag;
      for (int unsigned i = 1; i < CDC_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rsp_vld <= '0;
      if (w_tail.vld && cdc_bus.i_cdc_vld) begin
        r_rsp_vld  <= NUM_REQ'(1) << w_tail.id;
        r_rsp_data <= cdc_bus.i_cdc_data;
      end
      if (w_tail.vld != cdc_bus.i_cdc_vld) r_err <= 1'b1;
    end
  end

  assign cdc_bus.o_cdc_vld  = r_cdc_tag.vld;
  assign cdc_bus.o_cdc_data = r_cdc_data;
  assign cdc_bus.o_rsp_vld  = r_rsp_vld;
  assign cdc_bus.o_rsp_data = r_rsp_data;
  assign o_idle             = (r_state == ST_HALT);
  assign o_err              = r_err;

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] r_issue_cnt [NUM_REQ];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) r_issue_cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_xfer && w_gnt[k] && (r_issue_cnt[k] != 16'hFFFF))
          r_issue_cnt[k] <= r_issue_cnt[k] + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
    assign o_issue_cnt[k*16 +: 16] = r_issue_cnt[k];
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a delay-line cordic stand-in.
module tb_cordic_arbiter;
  import cordic_arb_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 49;
  localparam int LAT = 10;
  localparam logic [DW-1:0] CDC_XOR   = 49'h1_5A5A_C3C3_0FF0;
  localparam logic [DW-1:0] SPUR_DATA = 49'h0_1234_5678_9ABC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic drain = 1'b0;
  logic spur  = 1'b0;
  logic idle, err;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus();

`ifdef CORDIC_ARB_STATS_EN
  logic [NR*16-1:0] issue_cnt;
`endif

  cordic_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CDC_LAT(LAT)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .cdc_bus (bus),
    .i_drain (drain),
    .o_idle  (idle),
    .o_err   (err)
`ifdef CORDIC_ARB_STATS_EN
    ,
    .o_issue_cnt (issue_cnt)
`endif
  );

  // Cordic stand-in: fixed LAT-cycle delay and a reversible data transform.
  logic          cd_vld  [LAT];
  logic [DW-1:0] cd_data [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin cd_vld[i] <= 1'b0; cd_data[i] <= '0; end
    end else begin
      cd_vld[0]  <= bus.o_cdc_vld;
      cd_data[0] <= bus.o_cdc_data ^ CDC_XOR;
      for (int i = 1; i < LAT; i++) begin cd_vld[i] <= cd_vld[i-1]; cd_data[i] <= cd_data[i-1]; end
    end
  end
  assign bus.i_cdc_vld  = cd_vld[LAT-1] | spur;
  assign bus.i_cdc_data = spur ? SPUR_DATA : cd_data[LAT-1];

  typedef struct { int owner; logic [DW-1:0] data; longint due; } exp_t;
  exp_t sb[$];

  int     errs = 0, checks = 0;
  int     mdl_ptr = 0;
  bit     mdl_accept = 1'b1;
  int     mdl_cnt [NR];
  longint last_due = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand49();
    return DW'({$urandom, $urandom});
  endfunction

  function automatic logic [DW-1:0] req_word(input int k);
    return bus.i_req_data[k*DW +: DW];
  endfunction

  // Round-robin rule: first valid requester searching ptr, ptr+1, ... mod NR.
  function automatic int exp_grant();
    if (!mdl_accept || drain) return -1;
    for (int i = 0; i < NR; i++) begin
      if (bus.i_req_vld[(mdl_ptr + i) % NR]) return (mdl_ptr + i) % NR;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int k = 0; k < NR; k++) bus.i_req_data[k*DW +: DW] = rand49();
  endtask

  // Called at a falling edge with inputs set; checks the grant and advances one cycle.
  task automatic step();
    int g;
    #1;
    g = exp_grant();
    chk("grant", 64'(bus.o_req_rdy), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      sb.push_back('{g, req_word(g) ^ CDC_XOR, cyc + LAT + 2});
      last_due = cyc + LAT + 2;
      mdl_ptr  = (g + 1) % NR;
      if (mdl_cnt[g] < 65535) mdl_cnt[g]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.i_req_vld = '0;
    drain         = 1'b0;
    spur          = 1'b0;
    sb.delete();
    mdl_ptr    = 0;
    mdl_accept = 1'b1;
    for (int k = 0; k < NR; k++) mdl_cnt[k] = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy",  64'(bus.o_req_rdy), 0);
    chk("rst_cdc_vld",  64'(bus.o_cdc_vld), 0);
    chk("rst_cdc_data", 64'(bus.o_cdc_data), 0);
    chk("rst_rsp_vld",  64'(bus.o_rsp_vld), 0);
    chk("rst_rsp_data", 64'(bus.o_rsp_data), 0);
    chk("rst_idle",     64'(idle), 0);
    chk("rst_err",      64'(err), 0);
`ifdef CORDIC_ARB_STATS_EN
    chk("rst_issue_cnt", 64'(issue_cnt), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue n ops, raise drain, wait for halt, release and confirm grants resume.
  task automatic drain_seq(input int n, input bit pulse);
    bus.i_req_vld = 4'b1111;
    repeat (n) begin rand_data(); step(); end
    drain      = 1'b1;
    mdl_accept = 1'b0;
    step();
    if (pulse) drain = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) step();
    chk("idle_reached", 64'(idle), 1);
    chk("idle_cycle", 64'(cyc), 64'(last_due));
    drain = 1'b0;
    step();
    mdl_accept = 1'b1;
    chk("idle_one_cycle", 64'(idle), 0);
    rand_data();
    step();
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();
    chk("sb_drained", 64'(sb.size()), 0);
  endtask

  // Response monitor: every result must match the oldest expected operation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.o_rsp_vld != '0) begin
        if (sb.size() == 0) begin
          checks++; errs++;
          $display("FAIL rsp_unexpected: o_rsp_vld=%b with nothing expected (cycle %0d)", bus.o_rsp_vld, cyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_owner",   64'(bus.o_rsp_vld), 64'd1 << e.owner);
          chk("rsp_data",    64'(bus.o_rsp_data), 64'(e.data));
          chk("rsp_latency", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        checks++; errs++;
        $display("FAIL rsp_missing: requester %0d result due at cycle %0d never arrived", e.owner, e.due);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d1;
    bus.i_req_vld  = '0;
    bus.i_req_data = '0;
    do_reset();

    // Single requester, fixed payload.
    d1 = pack_op(1'b0, 16'h4000, 16'h0000, 16'h2000);
    bus.i_req_data[1*DW +: DW] = d1;
    bus.i_req_vld = 4'b0010;
    step();
    bus.i_req_vld = '0;
    chk("issue_vld",  64'(bus.o_cdc_vld), 1);
    chk("issue_data", 64'(bus.o_cdc_data), 64'(d1));
    step();
    chk("issue_vld_drop",  64'(bus.o_cdc_vld), 0);
    chk("issue_data_hold", 64'(bus.o_cdc_data), 64'(d1));
    repeat (LAT + 4) step();

    // All requesters asking from ptr=0.
    do_reset();
    bus.i_req_vld = 4'b1111;
    repeat (9) begin rand_data(); step(); end
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();

    // Random request patterns, including valids that drop while unserved.
    repeat (300) begin
      bus.i_req_vld = NR'($urandom);
      rand_data();
      step();
    end
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();
    chk("sb_empty_random", 64'(sb.size()), 0);

    drain_seq(3, 1'b0);
    drain_seq(2, 1'b1);

    // Spurious cordic valid with an empty tag pipe.
    chk("err_clear", 64'(err), 0);
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("err_set", 64'(err), 1);
    bus.i_req_vld = 4'b1001;
    repeat (2) begin rand_data(); step(); end
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();
    chk("err_sticky", 64'(err), 1);

    // Reset with five operations in flight.
    bus.i_req_vld = 4'b1111;
    repeat (5) begin rand_data(); step(); end
    bus.i_req_vld = '0;
    do_reset();
    repeat (LAT + 4) step();
    chk("post_rst_idle", 64'(idle), 0);
    drain      = 1'b1;
    mdl_accept = 1'b0;
    step();
    step();
    chk("post_rst_drain_halt", 64'(idle), 1);
    drain = 1'b0;
    step();
    mdl_accept = 1'b1;
    bus.i_req_vld = 4'b1111;
    rand_data();
    step();
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();

`ifdef CORDIC_ARB_STATS_EN
    do_reset();
    bus.i_req_vld = 4'b0100;
    repeat (1000) step();
    chk("cnt_mid", 64'(issue_cnt[32 +: 16]), 1000);
    repeat (69000) step();
    bus.i_req_vld = '0;
    repeat (LAT + 4) step();
    for (int k = 0; k < NR; k++) chk("issue_cnt", 64'(issue_cnt[k*16 +: 16]), 64'(mdl_cnt[k]));
    chk("cnt_saturated", 64'(issue_cnt[32 +: 16]), 64'hFFFF);
`else
    chk("final_sb_empty", 64'(sb.size()), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
